// File: rtl/axi_lite_arbiter_2x1.sv
// rtl/axi_lite_arbiter_2x1.sv - two-master round-robin AXI-lite arbiter, one transaction in flight
module axi_lite_arbiter_2x1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // master 0
  input  logic [ADDR_WIDTH-1:0] M0_AWADDR,
  input  logic                  M0_AWVALID,
  output logic                  M0_AWREADY,
  input  logic [DATA_WIDTH-1:0] M0_WDATA,
  input  logic                  M0_WVALID,
  output logic                  M0_WREADY,
  output logic                  M0_BVALID,
  input  logic                  M0_BREADY,
  input  logic [ADDR_WIDTH-1:0] M0_ARADDR,
  input  logic                  M0_ARVALID,
  output logic                  M0_ARREADY,
  output logic [DATA_WIDTH-1:0] M0_RDATA,
  output logic                  M0_RVALID,
  input  logic                  M0_RREADY,
  // master 1
  input  logic [ADDR_WIDTH-1:0] M1_AWADDR,
  input  logic                  M1_AWVALID,
  output logic                  M1_AWREADY,
  input  logic [DATA_WIDTH-1:0] M1_WDATA,
  input  logic                  M1_WVALID,
  output logic                  M1_WREADY,
  output logic                  M1_BVALID,
  input  logic                  M1_BREADY,
  input  logic [ADDR_WIDTH-1:0] M1_ARADDR,
  input  logic                  M1_ARVALID,
  output logic                  M1_ARREADY,
  output logic [DATA_WIDTH-1:0] M1_RDATA,
  output logic                  M1_RVALID,
  input  logic                  M1_RREADY,
  // slave
  output logic [ADDR_WIDTH-1:0] S_AWADDR,
  output logic                  S_AWVALID,
  input  logic                  S_AWREADY,
  output logic [DATA_WIDTH-1:0] S_WDATA,
  output logic                  S_WVALID,
  input  logic                  S_WREADY,
  input  logic                  S_BVALID,
  output logic                  S_BREADY,
  output logic [ADDR_WIDTH-1:0] S_ARADDR,
  output logic                  S_ARVALID,
  input  logic                  S_ARREADY,
  input  logic [DATA_WIDTH-1:0] S_RDATA,
  input  logic                  S_RVALID,
  output logic                  S_RREADY,
  // status
  output logic [1:0]            GRANT,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  state_t state;
  logic   g;
  logic   aw_done;
  logic   w_done;
  logic   last_grant;

  // signals of the currently granted master
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic                  m_awvalid;
  logic                  m_wvalid;
  logic                  m_bready;
  logic                  m_arvalid;
  logic                  m_rready;

  // state-gated handshakes seen from the granted master's side
  logic aw_ready_g;
  logic w_ready_g;
  logic b_valid_g;
  logic ar_ready_g;
  logic r_valid_g;

  logic req0;
  logic req1;
  logic pick;
  logic pick_aw;
  logic aw_hs;
  logic w_hs;

  // select the granted master's requests and payloads
  always_comb begin
    m_awaddr  = g ? M1_AWADDR  : M0_AWADDR;
    m_wdata   = g ? M1_WDATA   : M0_WDATA;
    m_araddr  = g ? M1_ARADDR  : M0_ARADDR;
    m_awvalid = g ? M1_AWVALID : M0_AWVALID;
    m_wvalid  = g ? M1_WVALID  : M0_WVALID;
    m_bready  = g ? M1_BREADY  : M0_BREADY;
    m_arvalid = g ? M1_ARVALID : M0_ARVALID;
    m_rready  = g ? M1_RREADY  : M0_RREADY;
  end

  // round-robin pick in IDLE: a tie goes to the master that did not win last time
  always_comb begin
    req0 = M0_AWVALID | M0_ARVALID;
    req1 = M1_AWVALID | M1_ARVALID;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else begin
      pick = req1 & ~req0;
    end
    pick_aw = pick ? M1_AWVALID : M0_AWVALID;
  end

  // slave-side request/response gating; payloads are zero outside their phase
  always_comb begin
    S_AWVALID  = (state == ST_WR_REQ) & ~aw_done & m_awvalid;
    S_WVALID   = (state == ST_WR_REQ) & ~w_done & m_wvalid;
    S_BREADY   = (state == ST_WR_RESP) & m_bready;
    S_ARVALID  = (state == ST_RD_ADDR) & m_arvalid;
    S_RREADY   = (state == ST_RD_DATA) & m_rready;
    S_AWADDR   = (state == ST_WR_REQ) ? m_awaddr : '0;
    S_WDATA    = (state == ST_WR_REQ) ? m_wdata : '0;
    S_ARADDR   = (state == ST_RD_ADDR) ? m_araddr : '0;
    aw_ready_g = (state == ST_WR_REQ) & ~aw_done & S_AWREADY;
    w_ready_g  = (state == ST_WR_REQ) & ~w_done & S_WREADY;
    b_valid_g  = (state == ST_WR_RESP) & S_BVALID;
    ar_ready_g = (state == ST_RD_ADDR) & S_ARREADY;
    r_valid_g  = (state == ST_RD_DATA) & S_RVALID;
    aw_hs      = S_AWVALID & S_AWREADY;
    w_hs       = S_WVALID & S_WREADY;
  end

  // route the gated handshakes to the granted master only; read data fans out
  always_comb begin
    M0_AWREADY = aw_ready_g & ~g;
    M0_WREADY  = w_ready_g & ~g;
    M0_BVALID  = b_valid_g & ~g;
    M0_ARREADY = ar_ready_g & ~g;
    M0_RVALID  = r_valid_g & ~g;
    M1_AWREADY = aw_ready_g & g;
    M1_WREADY  = w_ready_g & g;
    M1_BVALID  = b_valid_g & g;
    M1_ARREADY = ar_ready_g & g;
    M1_RVALID  = r_valid_g & g;
    M0_RDATA   = S_RDATA;
    M1_RDATA   = S_RDATA;
  end

  // transaction FSM with registered grant/busy status
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      g          <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      last_grant <= 1'b1;
      GRANT      <= 2'b00;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            g          <= pick;
            last_grant <= pick;
            GRANT      <= pick ? 2'b10 : 2'b01;
            BUSY       <= 1'b1;
            state      <= pick_aw ? ST_WR_REQ : ST_RD_ADDR;
          end
        end
        ST_WR_REQ: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_WR_RESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (S_BVALID && S_BREADY) begin
            state <= ST_IDLE;
            GRANT <= 2'b00;
            BUSY  <= 1'b0;
          end
        end
        ST_RD_ADDR: begin
          if (S_ARVALID && S_ARREADY) state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (S_RVALID && S_RREADY) begin
            state <= ST_IDLE;
            GRANT <= 2'b00;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          GRANT <= 2'b00;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2x1.sv
// tb/tb_axi_lite_arbiter_2x1.sv - directed self-checking bench for axi_lite_arbiter_2x1
module tb_axi_lite_arbiter_2x1;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] M0_AWADDR, M0_WDATA, M0_ARADDR, M0_RDATA;
  logic        M0_AWVALID, M0_AWREADY, M0_WVALID, M0_WREADY, M0_BVALID, M0_BREADY;
  logic        M0_ARVALID, M0_ARREADY, M0_RVALID, M0_RREADY;
  logic [31:0] M1_AWADDR, M1_WDATA, M1_ARADDR, M1_RDATA;
  logic        M1_AWVALID, M1_AWREADY, M1_WVALID, M1_WREADY, M1_BVALID, M1_BREADY;
  logic        M1_ARVALID, M1_ARREADY, M1_RVALID, M1_RREADY;
  logic [31:0] S_AWADDR, S_WDATA, S_ARADDR, S_RDATA;
  logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  logic [1:0]  GRANT;
  logic        BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_arbiter_2x1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_AWADDR(M0_AWADDR), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_WDATA(M0_WDATA), .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
    .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
    .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
    .M0_RDATA(M0_RDATA), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
    .M1_AWADDR(M1_AWADDR), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_WDATA(M1_WDATA), .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
    .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
    .M1_RDATA(M1_RDATA), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  // handshake outputs grouped: master 0, master 1, slave side
  wire [4:0] m0_hs = {M0_AWREADY, M0_WREADY, M0_BVALID, M0_ARREADY, M0_RVALID};
  wire [4:0] m1_hs = {M1_AWREADY, M1_WREADY, M1_BVALID, M1_ARREADY, M1_RVALID};
  wire [4:0] s_hs  = {S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  // advance one cycle; inputs change 1 ns after the edge
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    M0_AWADDR = '0; M0_AWVALID = 0; M0_WDATA = '0; M0_WVALID = 0; M0_BREADY = 0;
    M0_ARADDR = '0; M0_ARVALID = 0; M0_RREADY = 0;
    M1_AWADDR = '0; M1_AWVALID = 0; M1_WDATA = '0; M1_WVALID = 0; M1_BREADY = 0;
    M1_ARADDR = '0; M1_ARVALID = 0; M1_RREADY = 0;
    S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0; S_ARREADY = 0; S_RDATA = '0; S_RVALID = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESET = 1;
    tick();
    tick();
    ARESET = 0;
  endtask

  initial begin
    // reset with every input asserted
    clear_inputs();
    ARESET = 1;
    M0_AWVALID = 1; M0_WVALID = 1; M0_ARVALID = 1; M0_BREADY = 1; M0_RREADY = 1;
    M1_AWVALID = 1; M1_WVALID = 1; M1_ARVALID = 1; M1_BREADY = 1; M1_RREADY = 1;
    M0_AWADDR = 32'hDEAD_BEEF; M0_WDATA = 32'h5555_AAAA; M0_ARADDR = 32'h1111_2222;
    S_AWREADY = 1; S_WREADY = 1; S_BVALID = 1; S_ARREADY = 1; S_RVALID = 1;
    tick();
    tick();
    #1;
    check("rst_m0_hs", 64'(m0_hs), 64'h0);
    check("rst_m1_hs", 64'(m1_hs), 64'h0);
    check("rst_s_hs", 64'(s_hs), 64'h0);
    check("rst_grant", 64'(GRANT), 64'h0);
    check("rst_busy", 64'(BUSY), 64'h0);
    check("rst_awaddr", 64'(S_AWADDR), 64'h0);
    check("rst_wdata", 64'(S_WDATA), 64'h0);
    check("rst_araddr", 64'(S_ARADDR), 64'h0);

    // M0 single write, slave ready immediately, B one cycle later
    do_reset();
    M0_AWVALID = 1; M0_AWADDR = 32'h4000_0004;
    M0_WVALID = 1; M0_WDATA = 32'h1234_5678; M0_BREADY = 1;
    S_AWREADY = 1; S_WREADY = 1;
    #1;
    check("wr_idle_awready", 64'(M0_AWREADY), 64'h0);
    check("wr_idle_grant", 64'(GRANT), 64'h0);
    tick();
    #1;
    check("wr_grant", 64'(GRANT), 64'h1);
    check("wr_busy", 64'(BUSY), 64'h1);
    check("wr_s_awaddr", 64'(S_AWADDR), 64'h4000_0004);
    check("wr_s_wdata", 64'(S_WDATA), 64'h1234_5678);
    check("wr_s_valids", 64'({S_AWVALID, S_WVALID}), 64'h3);
    check("wr_m0_readys", 64'({M0_AWREADY, M0_WREADY}), 64'h3);
    check("wr_m1_hs", 64'(m1_hs), 64'h0);
    tick();
    M0_AWVALID = 0; M0_WVALID = 0; S_AWREADY = 0; S_WREADY = 0; S_BVALID = 1;
    #1;
    check("wr_m0_bvalid", 64'(M0_BVALID), 64'h1);
    check("wr_s_bready", 64'(S_BREADY), 64'h1);
    check("wr_resp_m1_hs", 64'(m1_hs), 64'h0);
    tick();
    S_BVALID = 0;
    #1;
    check("wr_done_busy", 64'(BUSY), 64'h0);
    check("wr_done_grant", 64'(GRANT), 64'h0);
    check("wr_done_m0_bvalid", 64'(M0_BVALID), 64'h0);

    // simultaneous M0 read and M1 write; grants alternate 01,10,01,10
    do_reset();
    M0_ARVALID = 1; M0_ARADDR = 32'h4000_0008; M0_RREADY = 1;
    M1_AWVALID = 1; M1_AWADDR = 32'h4000_000C;
    M1_WVALID = 1; M1_WDATA = 32'h0BAD_F00D; M1_BREADY = 1;
    S_ARREADY = 1; S_AWREADY = 1; S_WREADY = 1;
    tick();
    #1;
    check("rr_grant1", 64'(GRANT), 64'h1);
    check("rr_s_araddr", 64'(S_ARADDR), 64'h4000_0008);
    check("rr_m0_arready", 64'(M0_ARREADY), 64'h1);
    check("rr_m1_held", 64'(m1_hs), 64'h0);
    tick();
    S_RVALID = 1; S_RDATA = 32'hCAFE_0001;
    #1;
    check("rr_m0_rvalid", 64'(M0_RVALID), 64'h1);
    check("rr_m0_rdata", 64'(M0_RDATA), 64'hCAFE_0001);
    tick();
    S_RVALID = 0;
    #1;
    check("rr_idle_busy", 64'(BUSY), 64'h0);
    tick();
    #1;
    check("rr_grant2", 64'(GRANT), 64'h2);
    check("rr_s_awaddr", 64'(S_AWADDR), 64'h4000_000C);
    check("rr_m1_awready", 64'(M1_AWREADY), 64'h1);
    tick();
    S_BVALID = 1;
    #1;
    check("rr_m1_bvalid", 64'(M1_BVALID), 64'h1);
    tick();
    S_BVALID = 0;
    tick();
    #1;
    check("rr_grant3", 64'(GRANT), 64'h1);
    tick();
    S_RVALID = 1;
    tick();
    S_RVALID = 0;
    tick();
    #1;
    check("rr_grant4", 64'(GRANT), 64'h2);

    // M1 write with AWREADY in cycle 1 and WREADY in cycle 3
    do_reset();
    M1_AWVALID = 1; M1_AWADDR = 32'h4000_0010;
    M1_WVALID = 1; M1_WDATA = 32'h0000_00A5; M1_BREADY = 1;
    tick();
    S_AWREADY = 1;
    #1;
    check("sk_c1_awvalid", 64'(S_AWVALID), 64'h1);
    check("sk_c1_m1_awready", 64'(M1_AWREADY), 64'h1);
    check("sk_c1_m1_wready", 64'(M1_WREADY), 64'h0);
    tick();
    S_AWREADY = 0;
    #1;
    check("sk_c2_awvalid", 64'(S_AWVALID), 64'h0);
    check("sk_c2_wvalid", 64'(S_WVALID), 64'h1);
    check("sk_c2_grant", 64'(GRANT), 64'h2);
    check("sk_c2_bvalid", 64'(M1_BVALID), 64'h0);
    tick();
    S_WREADY = 1;
    #1;
    check("sk_c3_m1_wready", 64'(M1_WREADY), 64'h1);
    check("sk_c3_awvalid", 64'(S_AWVALID), 64'h0);
    tick();
    M1_AWVALID = 0; M1_WVALID = 0; S_WREADY = 0; S_BVALID = 1;
    #1;
    check("sk_m1_bvalid", 64'(M1_BVALID), 64'h1);
    tick();
    S_BVALID = 0;
    #1;
    check("sk_done_bvalid", 64'(M1_BVALID), 64'h0);
    check("sk_done_busy", 64'(BUSY), 64'h0);

    // M0 read with master R back-pressure for three cycles
    do_reset();
    M0_ARVALID = 1; M0_ARADDR = 32'h4000_0020; M0_RREADY = 0;
    S_ARREADY = 1;
    tick();
    tick();
    M0_ARVALID = 0; S_ARREADY = 0;
    S_RVALID = 1; S_RDATA = 32'hBEEF_0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_s_rready", 64'(S_RREADY), 64'h0);
      check("bp_grant", 64'(GRANT), 64'h1);
      check("bp_rdata", 64'(M0_RDATA), 64'hBEEF_0002);
      check("bp_rvalid", 64'(M0_RVALID), 64'h1);
      tick();
    end
    M0_RREADY = 1;
    #1;
    check("bp_release_rready", 64'(S_RREADY), 64'h1);
    tick();
    S_RVALID = 0;
    #1;
    check("bp_done_busy", 64'(BUSY), 64'h0);

    // reset pulse during RD_DATA, then a tie must go to M0
    do_reset();
    M0_ARVALID = 1; M0_ARADDR = 32'h4000_0030; S_ARREADY = 1;
    tick();
    tick();
    M0_ARVALID = 0; S_ARREADY = 0; S_RVALID = 1; S_RDATA = 32'h7777_0003;
    #1;
    check("mr_in_rdata", 64'(M0_RVALID), 64'h1);
    ARESET = 1;
    tick();
    ARESET = 0;
    #1;
    check("mr_busy", 64'(BUSY), 64'h0);
    check("mr_grant", 64'(GRANT), 64'h0);
    check("mr_m0_hs", 64'(m0_hs), 64'h0);
    check("mr_s_hs", 64'(s_hs), 64'h0);
    S_RVALID = 0;
    M0_ARVALID = 1; M1_ARVALID = 1;
    tick();
    #1;
    check("mr_tie_grant", 64'(GRANT), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
